// File: rtl/gsm_sch_pkg.sv
// Shared definitions for the GSM switch scheduler slice: FSM encoding and default sizing.
// Used by the VOQ request generator and by rr_sch_16.
package gsm_sch_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } sch_state_e;

    localparam int unsigned DEF_NUM_PORT     = 32'd4;
    localparam int unsigned DEF_LOG_NUM_PORT = 32'd2;
    localparam int unsigned DEF_BURST_LEN    = 32'd4;
    localparam int unsigned DEF_LOG_BURST    = 32'd2;

endpackage

// File: rtl/onehot_enc.sv
// Encodes a scheduler grant vector into its bit index and flags whether exactly one bit is set.
module onehot_enc #(
    parameter int unsigned NUM_PORT     = 32'd4,
    parameter int unsigned LOG_NUM_PORT = 32'd2
) (
    input  logic [NUM_PORT-1:0]     vec_i,
    output logic [LOG_NUM_PORT-1:0] idx_o,
    output logic                    is_onehot_o
);

    // Index of the highest set bit; only meaningful when is_onehot_o is set
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < int'(NUM_PORT); i++) begin
            if (vec_i[i]) begin
                idx_o = LOG_NUM_PORT'(i);
            end else begin
                idx_o = idx_o;
            end
        end
    end

    assign is_onehot_o = (vec_i != '0) && ((vec_i & (vec_i - NUM_PORT'(1))) == '0);

endmodule

// File: rtl/voq_req_gen.sv
// Requester front end for one rr_sch instance: per-VOQ packet counters drive req/stall,
// and an accepted grant becomes a fixed-length burst read command to packet memory.
module voq_req_gen
    import gsm_sch_pkg::*;
#(
    parameter int unsigned NUM_PORT     = DEF_NUM_PORT,
    parameter int unsigned LOG_NUM_PORT = DEF_LOG_NUM_PORT,
    parameter int unsigned CNT_WIDTH    = 32'd8,
    parameter int unsigned BURST_LEN    = DEF_BURST_LEN,
    parameter int unsigned LOG_BURST    = DEF_LOG_BURST
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    enq_valid,
    input  logic [LOG_NUM_PORT-1:0] enq_qid,
    output logic                    enq_drop,
    output logic [NUM_PORT-1:0]     req,
    output logic                    stall,
    input  logic [NUM_PORT-1:0]     grant,
    output logic                    err_grant,
    input  logic                    mem_ready,
    output logic                    rd_valid,
    output logic [LOG_NUM_PORT-1:0] rd_qid,
    output logic                    rd_last
);

    localparam logic [LOG_BURST-1:0] LAST_BEAT = LOG_BURST'(BURST_LEN - 32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    sch_state_e              state_q, state_d;
    logic [LOG_BURST-1:0]    beat_q, beat_d;
    logic [LOG_NUM_PORT-1:0] rd_qid_q, rd_qid_d;
    logic [LOG_NUM_PORT-1:0] gnt_idx_s;
    logic                    gnt_onehot_s, gnt_legal_s, accept_s;
    logic                    err_grant_q, err_grant_d;
    logic                    enq_drop_q;
    logic [NUM_PORT-1:0]     req_q;
    logic [NUM_PORT-1:0]     cnt_nz_q, cnt_nz_d, drop_s;

    onehot_enc #(
        .NUM_PORT     (NUM_PORT),
        .LOG_NUM_PORT (LOG_NUM_PORT)
    ) u_gnt_enc (
        .vec_i       (grant),
        .idx_o       (gnt_idx_s),
        .is_onehot_o (gnt_onehot_s)
    );

    // A grant to an empty VOQ would underflow its counter, so it is treated as illegal
    assign gnt_legal_s = gnt_onehot_s && cnt_nz_q[gnt_idx_s];

    for (genvar i = 0; i < NUM_PORT; i++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 hit_s, dec_s, full_s;

        assign hit_s       = enq_valid && (enq_qid == LOG_NUM_PORT'(i));
        assign dec_s       = accept_s && (gnt_idx_s == LOG_NUM_PORT'(i));
        assign full_s      = (cnt_q == CNT_MAX);
        assign drop_s[i]   = hit_s && full_s && !dec_s;
        assign cnt_nz_q[i] = (cnt_q != '0);
        assign cnt_nz_d[i] = (cnt_d != '0);

        // Counter next state; a simultaneous enq and grant on this VOQ cancel out
        always_comb begin
            if (clr) begin
                cnt_d = '0;
            end else if (hit_s && !dec_s && !full_s) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end else if (dec_s && !hit_s) begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end

        // Counter register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Transfer FSM next state and grant checking
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        rd_qid_d    = rd_qid_q;
        err_grant_d = 1'b0;
        accept_s    = 1'b0;
        if (clr) begin
            state_d  = ST_IDLE;
            beat_d   = '0;
            rd_qid_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant != '0) begin
                        if (gnt_legal_s) begin
                            accept_s = 1'b1;
                            state_d  = ST_XFER;
                            rd_qid_d = gnt_idx_s;
                            beat_d   = '0;
                        end else begin
                            err_grant_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_XFER: begin
                    err_grant_d = (grant != '0);
                    if (mem_ready) begin
                        if (beat_q == LAST_BEAT) begin
                            state_d = ST_IDLE;
                            beat_d  = '0;
                        end else begin
                            beat_d = beat_q + LOG_BURST'(1);
                        end
                    end else begin
                        beat_d = beat_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end
            endcase
        end
    end

    // FSM and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            rd_qid_q    <= '0;
            err_grant_q <= 1'b0;
            enq_drop_q  <= 1'b0;
            req_q       <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            rd_qid_q    <= rd_qid_d;
            err_grant_q <= err_grant_d;
            enq_drop_q  <= clr ? 1'b0 : (|drop_s);
            req_q       <= cnt_nz_d;
        end
    end

    assign req       = req_q;
    assign stall     = (state_q == ST_XFER);
    assign rd_valid  = (state_q == ST_XFER);
    assign rd_qid    = rd_qid_q;
    assign rd_last   = rd_valid && (beat_q == LAST_BEAT);
    assign enq_drop  = enq_drop_q;
    assign err_grant = err_grant_q;

endmodule

// File: tb/tb_voq_req_gen.sv
// Self-checking bench for voq_req_gen: directed scenarios plus randomized traffic against
// a behavioural model, and a BURST_LEN=1 instance for single-beat bursts.
module tb_voq_req_gen;

    localparam int NP   = 4;
    localparam int BL   = 4;
    localparam int CMAX = 255;

    logic       clk = 1'b0;
    logic       rst_n, clr, enq_valid, mem_ready;
    logic [1:0] enq_qid;
    logic [3:0] grant;
    logic       enq_drop, stall, err_grant, rd_valid, rd_last;
    logic [3:0] req;
    logic [1:0] rd_qid;

    logic       b_enq_valid, b_mem_ready;
    logic [1:0] b_enq_qid;
    logic [3:0] b_grant;
    logic       b_enq_drop, b_stall, b_err_grant, b_rd_valid, b_rd_last;
    logic [3:0] b_req;
    logic [1:0] b_rd_qid;

    int n_checks = 0;
    int n_fail   = 0;

    int m_cnt[NP];
    bit m_busy, m_drop, m_err;
    int m_qid, m_beat;

    always #5 clk = ~clk;

    voq_req_gen u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .enq_valid(enq_valid), .enq_qid(enq_qid), .enq_drop(enq_drop),
        .req(req), .stall(stall), .grant(grant), .err_grant(err_grant),
        .mem_ready(mem_ready), .rd_valid(rd_valid), .rd_qid(rd_qid), .rd_last(rd_last)
    );

    voq_req_gen #(.BURST_LEN(1), .LOG_BURST(1)) u_dut_b1 (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .enq_valid(b_enq_valid), .enq_qid(b_enq_qid), .enq_drop(b_enq_drop),
        .req(b_req), .stall(b_stall), .grant(b_grant), .err_grant(b_err_grant),
        .mem_ready(b_mem_ready), .rd_valid(b_rd_valid), .rd_qid(b_rd_qid), .rd_last(b_rd_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_cnt[i] = 0;
        m_busy = 1'b0; m_drop = 1'b0; m_err = 1'b0;
        m_qid = 0; m_beat = 0;
    endtask

    // One clock edge of the queue manager, described as packet bookkeeping
    task automatic model_step();
        int ones, gidx, dec;
        m_drop = 1'b0;
        m_err  = 1'b0;
        if (clr) begin
            model_reset();
            return;
        end
        ones = $countones(grant);
        gidx = 0;
        for (int i = 0; i < NP; i++) if (grant[i]) gidx = i;
        dec = -1;
        if (!m_busy) begin
            if (grant != 4'b0000) begin
                if (ones == 1 && m_cnt[gidx] > 0) begin
                    dec = gidx; m_busy = 1'b1; m_qid = gidx; m_beat = 0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else begin
            if (grant != 4'b0000) m_err = 1'b1;
            if (mem_ready) begin
                if (m_beat == BL - 1) begin
                    m_busy = 1'b0; m_beat = 0;
                end else begin
                    m_beat++;
                end
            end
        end
        if (!(enq_valid && dec == int'(enq_qid))) begin
            if (enq_valid) begin
                if (m_cnt[enq_qid] == CMAX) m_drop = 1'b1;
                else m_cnt[enq_qid]++;
            end
            if (dec >= 0) m_cnt[dec]--;
        end
    endtask

    task automatic check_outputs();
        logic [3:0] exp_req;
        for (int i = 0; i < NP; i++) exp_req[i] = (m_cnt[i] != 0);
        chk("req", req, exp_req);
        chk("stall", stall, m_busy);
        chk("rd_valid", rd_valid, m_busy);
        if (m_busy) chk("rd_qid", rd_qid, m_qid);
        chk("rd_last", rd_last, m_busy && (m_beat == BL - 1));
        chk("enq_drop", enq_drop, m_drop);
        chk("err_grant", err_grant, m_err);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        clr = 1'b0; enq_valid = 1'b0; enq_qid = 2'd0; grant = 4'b0000; mem_ready = 1'b1;
    endtask

    initial begin
        int lasts, stalls, drops, r;
        rst_n = 1'b0;
        idle_inputs();
        b_enq_valid = 1'b0; b_enq_qid = 2'd0; b_grant = 4'b0000; b_mem_ready = 1'b1;
        model_reset();
        #12;
        chk("rst_req", req, 4'b0000);
        chk("rst_stall", stall, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_qid", rd_qid, 2'd0);
        chk("rst_rd_last", rd_last, 1'b0);
        chk("rst_enq_drop", enq_drop, 1'b0);
        chk("rst_err_grant", err_grant, 1'b0);
        rst_n = 1'b1;
        #10;

        // Basic burst: two packets in VOQ2, one granted
        enq_valid = 1'b1; enq_qid = 2'd2;
        cycle(); cycle();
        enq_valid = 1'b0; grant = 4'b0100;
        cycle();
        grant = 4'b0000;
        chk("t1_qid", rd_qid, 2'd2);
        chk("t1_req", req, 4'b0100);
        lasts = 0; stalls = 1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (rd_last) lasts++;
            if (stall) stalls++;
        end
        chk("t1_stall_len", stalls, BL);
        chk("t1_last_once", lasts, 1);

        // Back-pressure mid-burst
        grant = 4'b0100;
        cycle();
        grant = 4'b0000;
        lasts = 0;
        for (int k = 0; k < 8; k++) begin
            mem_ready = !(k >= 1 && k <= 3);
            cycle();
            if (rd_last) lasts++;
        end
        mem_ready = 1'b1;
        chk("t2_last_once", lasts, 1);
        chk("t2_req_empty", req, 4'b0000);

        // Enq and grant on the same VOQ in the same cycle
        enq_valid = 1'b1; enq_qid = 2'd1;
        cycle(); cycle();
        grant = 4'b0010;
        cycle(); grant = 4'b0000;
        cycle(); cycle(); cycle(); cycle();
        enq_valid = 1'b0;
        cycle();

        // Saturation on VOQ3
        clr = 1'b1; cycle(); clr = 1'b0;
        enq_valid = 1'b1; enq_qid = 2'd3;
        drops = 0;
        for (int k = 0; k < 256; k++) begin
            cycle();
            if (enq_drop) drops++;
        end
        enq_valid = 1'b0;
        cycle();
        if (enq_drop) drops++;
        chk("t3_drop_once", drops, 1);

        // Illegal grants
        clr = 1'b1; cycle(); clr = 1'b0;
        enq_valid = 1'b1; enq_qid = 2'd1; cycle(); enq_valid = 1'b0;
        grant = 4'b0011; cycle();
        chk("t4_multihot_err", err_grant, 1'b1);
        grant = 4'b0001; cycle();
        chk("t4_empty_err", err_grant, 1'b1);
        chk("t4_empty_nostall", stall, 1'b0);
        grant = 4'b0010; cycle();
        grant = 4'b1000; cycle();
        chk("t4_xfer_err", err_grant, 1'b1);
        grant = 4'b0000;
        cycle(); cycle(); cycle();

        // clr on the second beat
        enq_valid = 1'b1; enq_qid = 2'd0; cycle(); cycle(); enq_valid = 1'b0;
        grant = 4'b0001; cycle(); grant = 4'b0000;
        cycle();
        clr = 1'b1; cycle(); clr = 1'b0;
        chk("t5_clr_stall", stall, 1'b0);
        chk("t5_clr_req", req, 4'b0000);
        chk("t5_clr_qid", rd_qid, 2'd0);
        cycle();

        // Asynchronous reset on the second beat
        enq_valid = 1'b1; enq_qid = 2'd2; cycle(); cycle(); enq_valid = 1'b0;
        grant = 4'b0100; cycle(); grant = 4'b0000;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("t5_arst_stall", stall, 1'b0);
        chk("t5_arst_valid", rd_valid, 1'b0);
        chk("t5_arst_last", rd_last, 1'b0);
        chk("t5_arst_req", req, 4'b0000);
        chk("t5_arst_qid", rd_qid, 2'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #2;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            enq_valid = ($urandom_range(0, 1) == 1);
            enq_qid   = 2'($urandom_range(0, 3));
            mem_ready = ($urandom_range(0, 9) < 7);
            clr       = ($urandom_range(0, 299) == 0);
            r = $urandom_range(0, 9);
            if (!m_busy) begin
                if (r < 5)       grant = 4'b0001 << $urandom_range(0, 3);
                else if (r == 5) grant = 4'($urandom_range(0, 15));
                else             grant = 4'b0000;
            end else begin
                grant = (r == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            end
            cycle();
        end
        idle_inputs();
        cycle();

        // Single-beat bursts on the BURST_LEN=1 instance
        b_enq_valid = 1'b1; b_enq_qid = 2'd3;
        @(posedge clk); #1;
        b_enq_qid = 2'd0;
        @(posedge clk); #1;
        b_enq_valid = 1'b0; b_grant = 4'b1000;
        @(posedge clk); #1;
        b_grant = 4'b0000;
        chk("t6_g1_valid", b_rd_valid, 1'b1);
        chk("t6_g1_last", b_rd_last, 1'b1);
        chk("t6_g1_qid", b_rd_qid, 2'd3);
        chk("t6_g1_stall", b_stall, 1'b1);
        @(posedge clk); #1;
        chk("t6_mid_stall", b_stall, 1'b0);
        chk("t6_mid_req", b_req, 4'b0001);
        b_grant = 4'b0001;
        @(posedge clk); #1;
        b_grant = 4'b0000;
        chk("t6_g2_valid", b_rd_valid, 1'b1);
        chk("t6_g2_last", b_rd_last, 1'b1);
        chk("t6_g2_qid", b_rd_qid, 2'd0);
        @(posedge clk); #1;
        chk("t6_end_stall", b_stall, 1'b0);
        chk("t6_end_req", b_req, 4'b0000);
        chk("t6_end_err", b_err_grant, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
